// File: rtl/riscy_pkg.sv
// Shared riscy32 definitions: datapath width, reset vector, canonical nop and
// the fetch-stage state encoding.
package riscy_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: sequential pc+4 or a redirect target with its low two
// bits cleared, flagging targets that were not word aligned.
module pc_next #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned
);

    // Adder wraps modulo 2^XLEN; redirect targets are forced to word alignment.
    always_comb begin
        pc_plus4 = pc + XLEN'(32'd4);
        if (PCSrc) begin
            next_pc    = {PCTarget[XLEN-1:2], 2'b00};
            misaligned = (PCTarget[1:0] != 2'b00);
        end else begin
            next_pc    = pc_plus4;
            misaligned = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// riscy32 instruction fetch: owns the PC, issues one imem request at a time and
// holds each fetched instruction until decode accepts it.
module fetch_unit #(
    parameter int               XLEN     = riscy_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = riscy_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned
);

    import riscy_pkg::*;

    fetch_state_t    state_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] pc_r;
    logic [31:0]     instr_r;
    logic            instr_valid_r;
    logic            misaligned_r;
    logic            req_r;
    logic [XLEN-1:0] next_pc_s;
    logic            misaligned_s;

    pc_next #(.XLEN(XLEN)) u_pc_next (
        .pc         (pc_r),
        .PCSrc      (PCSrc),
        .PCTarget   (PCTarget),
        .next_pc    (next_pc_s),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned_s)
    );

    // Fetch FSM with registered request, instruction and PC outputs.
    // req_r starts low so no grant can be taken in the cycle reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= REQ;
            fetch_pc_r    <= RESET_PC;
            pc_r          <= RESET_PC;
            instr_r       <= NOP_INSTR;
            instr_valid_r <= 1'b0;
            misaligned_r  <= 1'b0;
            req_r         <= 1'b0;
        end else begin
            misaligned_r <= 1'b0;
            case (state_r)
                REQ: begin
                    if (req_r && imem_gnt) begin
                        req_r   <= 1'b0;
                        state_r <= WAIT;
                    end else begin
                        req_r <= 1'b1;
                    end
                end
                WAIT: begin
                    req_r <= 1'b0;
                    if (imem_rvalid) begin
                        instr_r       <= imem_rdata;
                        pc_r          <= fetch_pc_r;
                        instr_valid_r <= 1'b1;
                        state_r       <= HOLD;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                HOLD: begin
                    if (instr_valid_r && instr_ready) begin
                        fetch_pc_r    <= next_pc_s;
                        misaligned_r  <= misaligned_s;
                        instr_valid_r <= 1'b0;
                        req_r         <= 1'b1;
                        state_r       <= REQ;
                    end else begin
                        req_r <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= REQ;
                    instr_valid_r <= 1'b0;
                    req_r         <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = fetch_pc_r;
    assign instr       = instr_r;
    assign pc          = pc_r;
    assign instr_valid = instr_valid_r;
    assign misaligned  = misaligned_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, stall and reset
// sequences, then randomized memory/decode traffic against a PC-level model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misaligned  (misaligned)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;
    logic        mem_en;
    int          gnt_pct;
    int          max_dly;
    logic        stray_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0050_0093;
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model: grants requests, returns data after a random delay, and
    // optionally injects orphan rvalid pulses that the fetch unit must drop.
    initial begin
        logic        pend;
        logic [31:0] paddr;
        int          dly;
        logic        prev_req;
        logic [31:0] prev_addr;
        pend = 1'b0; paddr = 32'h0; dly = 0; prev_req = 1'b0; prev_addr = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (rst) begin
                    pend = 1'b0; prev_req = 1'b0;
                    imem_gnt = 1'b0; imem_rvalid = 1'b0;
                end else begin
                    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = $urandom;
                    if (pend) begin
                        check("one_outstanding", {31'd0, imem_req}, 32'd0);
                        if (dly == 0) begin
                            imem_rvalid = 1'b1;
                            imem_rdata  = instr_of(paddr);
                            pend = 1'b0;
                        end else begin
                            dly--;
                        end
                    end else begin
                        if (imem_req) begin
                            if (prev_req) check("req_addr_stable", imem_addr, prev_addr);
                            if ($urandom_range(1, 100) <= gnt_pct) begin
                                check("fetch_addr", imem_addr, exp_pc);
                                imem_gnt = 1'b1;
                                pend = 1'b1;
                                paddr = imem_addr;
                                dly = $urandom_range(0, max_dly);
                                prev_req = 1'b0;
                            end else begin
                                prev_req = 1'b1;
                                prev_addr = imem_addr;
                            end
                        end else begin
                            prev_req = 1'b0;
                        end
                        if (stray_en && $urandom_range(0, 3) == 0) begin
                            imem_rvalid = 1'b1;
                            imem_rdata  = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        src;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] nxt;
        logic        mis;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int   cnt;
        int   first_req;
        int   valid_at;
        int   since;
        int   n_hs;
        logic exp_mis;
        logic hs_prev;

        tbl[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 32'h0000_0004, 1'b0};
        tbl[1] = '{1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_0008, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0040, 32'h0000_0008, 32'h0000_000C, 32'h0000_0040, 1'b0};
        tbl[3] = '{1'b1, 32'h0000_0042, 32'h0000_0040, 32'h0000_0044, 32'h0000_0040, 1'b1};
        tbl[4] = '{1'b0, 32'h0000_0000, 32'h0000_0040, 32'h0000_0044, 32'h0000_0044, 1'b0};
        tbl[5] = '{1'b1, 32'hFFFF_FFFE, 32'h0000_0044, 32'h0000_0048, 32'hFFFF_FFFC, 1'b1};
        tbl[6] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[7] = '{1'b1, 32'h0000_0101, 32'h0000_0000, 32'h0000_0004, 32'h0000_0100, 1'b1};

        rst = 1'b1; PCSrc = 1'b0; PCTarget = 32'h0; instr_ready = 1'b0;
        exp_pc = 32'h0; mem_en = 1'b1; gnt_pct = 100; max_dly = 0; stray_en = 1'b0;

        // Reset values and release, then first-fetch latency.
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        check("rst_pc", pc, 32'h0000_0000);
        check("rst_instr", instr, 32'h0000_0013);
        rst = 1'b0;
        first_req = -1; valid_at = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (imem_req && first_req < 0) begin
                first_req = k;
                check("first_addr", imem_addr, 32'h0000_0000);
            end
            if (instr_valid) begin
                valid_at = k;
                break;
            end
        end
        check("first_latency", 32'(valid_at - first_req), 32'd2);

        // Directed vector table with zero-wait memory.
        for (int i = 0; i < 8; i++) begin
            cnt = 0;
            while (!instr_valid && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            check("tbl_valid", {31'd0, instr_valid}, 32'd1);
            if (i > 0) check("tbl_throughput", 32'(cnt), 32'd1);
            check("tbl_pc", pc, tbl[i].pc);
            check("tbl_pc4", pc_plus4, tbl[i].pc4);
            check("tbl_instr", instr, instr_of(tbl[i].pc));
            instr_ready = 1'b1; PCSrc = tbl[i].src; PCTarget = tbl[i].tgt;
            exp_pc = tbl[i].nxt;
            @(negedge clk);
            instr_ready = 1'b0; PCSrc = 1'b0;
            check("tbl_mis", {31'd0, misaligned}, {31'd0, tbl[i].mis});
            check("tbl_valid_drop", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
            check("tbl_mis_end", {31'd0, misaligned}, 32'd0);
        end

        // Decode stall: outputs frozen, PCSrc noise ignored.
        cnt = 0;
        while (!instr_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        for (int s = 0; s < 5; s++) begin
            PCSrc = ~PCSrc; PCTarget = $urandom;
            @(negedge clk);
            check("stall_pc", pc, 32'h0000_0100);
            check("stall_instr", instr, instr_of(32'h0000_0100));
            check("stall_req", {31'd0, imem_req}, 32'd0);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        instr_ready = 1'b1; PCSrc = 1'b0; exp_pc = 32'h0000_0104;
        @(negedge clk);
        instr_ready = 1'b0;
        check("stall_release_mis", {31'd0, misaligned}, 32'd0);
        check("stall_release_req", {31'd0, imem_req}, 32'd1);

        // Randomized traffic against the PC-level model.
        gnt_pct = 60; max_dly = 3; stray_en = 1'b1;
        exp_mis = 1'b0; hs_prev = 1'b0; since = 0; n_hs = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            check("rnd_mis", {31'd0, misaligned}, {31'd0, exp_mis});
            exp_mis = 1'b0;
            if (hs_prev) check("rnd_valid_drop", {31'd0, instr_valid}, 32'd0);
            hs_prev = 1'b0;
            PCSrc = 1'($urandom_range(0, 1));
            PCTarget = $urandom;
            instr_ready = 1'($urandom_range(0, 1));
            if (instr_valid) begin
                check("rnd_pc", pc, exp_pc);
                check("rnd_pc4", pc_plus4, exp_pc + 32'd4);
                check("rnd_instr", instr, instr_of(exp_pc));
                if (instr_ready) begin
                    hs_prev = 1'b1; n_hs++; since = 0;
                    if (PCSrc) begin
                        exp_mis = (PCTarget % 32'd4) != 32'd0;
                        exp_pc  = PCTarget & ~32'd3;
                    end else begin
                        exp_pc = exp_pc + 32'd4;
                    end
                end
            end
            since++;
            if (since > 80) begin
                check("rnd_progress", 32'(since), 32'd0);
                break;
            end
        end
        check("rnd_handshakes_seen", {31'd0, n_hs > 50}, 32'd1);

        // Reset during WAIT, stale rvalid after release.
        @(posedge clk); #2;
        rst = 1'b1; mem_en = 1'b0; instr_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        @(negedge clk);
        check("r2_req", {31'd0, imem_req}, 32'd0);
        check("r2_valid", {31'd0, instr_valid}, 32'd0);
        check("r2_addr", imem_addr, 32'h0000_0000);
        check("r2_instr", instr, 32'h0000_0013);
        rst = 1'b0;
        @(negedge clk);
        check("r3_req", {31'd0, imem_req}, 32'd1);
        imem_gnt = 1'b1;
        @(posedge clk); #2;
        imem_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("wait_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("wait_rst_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("stale_valid", {31'd0, instr_valid}, 32'd0);
        check("stale_req", {31'd0, imem_req}, 32'd1);
        check("stale_addr", imem_addr, 32'h0000_0000);
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        check("refetch_req_low", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("refetch_valid", {31'd0, instr_valid}, 32'd1);
        check("refetch_instr", instr, 32'h0050_0093);
        check("refetch_pc", pc, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the riscy32 core.
- Owns the PC register and fetches 32-bit instructions from instruction memory over a req/gnt/rvalid handshake.
- Presents each instruction to decode/control with a valid/ready handshake.
- Consumes control's PCSrc and the branch/jump target to choose the next PC. It sits at the receiving end of control's PC-redirect interface.

Parameters:
- XLEN, 32, address/data width of PC and targets.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCSrc  in  1  from control; 1 = take PCTarget for the instruction being consumed.
- PCTarget  in  XLEN  branch/jal target for the instruction being consumed.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address; word aligned.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/pc hold a valid instruction.
- instr_ready  in  1  decode consumes the instruction this cycle.
- instr  out  32  fetched instruction.
- pc  out  XLEN  address of instr.
- pc_plus4  out  XLEN  pc + 4.
- misaligned  out  1  one-cycle pulse: redirect target had a nonzero [1:0].

Behaviour:
- Reset is asynchronous and active-high, with one clock.
- Reset values: state=REQ, fetch_pc=RESET_PC, pc=RESET_PC, instr=32'h0000_0013 (nop), instr_valid=0, misaligned=0.
- imem_req is 0 while rst is high and 1 in the first cycle after release.
- At most one request is outstanding.
- States:
  - REQ: imem_req=1, imem_addr=fetch_pc. On imem_gnt go to WAIT. Without gnt, hold req and addr stable.
  - WAIT: imem_req=0. On imem_rvalid, register imem_rdata->instr and fetch_pc->pc, set instr_valid=1, go to HOLD. imem_rvalid is ignored in REQ and HOLD (drops orphan responses).
  - HOLD: instr_valid=1; instr and pc stay stable until handshake. On instr_valid && instr_ready: next = PCSrc ? {PCTarget[XLEN-1:2],2'b00} : pc+4. Load fetch_pc=next, clear instr_valid, go to REQ.
- misaligned: pulses for 1 cycle after a taken redirect with PCTarget[1:0]!=0. The low bits are forced to zero.
- PCSrc and PCTarget are sampled only on the handshake cycle; all other values are don't-care.
- Latency: with gnt in the request cycle and rvalid the next cycle, instr_valid rises 2 cycles after imem_req first asserts. Throughput is 1 instruction per 3 cycles with zero-wait memory and ready held high.
- Arithmetic: pc+4 wraps modulo 2^XLEN; 32'hFFFF_FFFC+4 = 0.
- Reset mid-operation (any state) returns immediately to reset values. The in-flight response is dropped.
- imem_gnt and imem_rvalid asserted in the same cycle while in REQ: gnt is taken, rvalid is ignored.

Decomposition:
- Shared package riscy_pkg: XLEN, RESET_PC, NOP_INSTR (32'h00000013), typedef enum fetch_state_t {REQ, WAIT, HOLD}.
- One natural sub-module: pc_next, a combinational next-PC mux/adder (pc, PCSrc, PCTarget -> next_pc, pc_plus4, misaligned). It is reused later by the pipelined core.

Test Plan:
1. Reset release, memory gnt same cycle and rvalid next with rdata=32'h00500093 -> imem_addr=0. instr_valid rises 2 cycles after imem_req; instr=32'h00500093, pc=0, pc_plus4=4.
2. Sequential fetch with instr_ready=1, PCSrc=0 for 3 instructions -> imem_addr sequence 0, 4, 8; pc sequence 0, 4, 8.
3. At pc=8, PCSrc=1 and PCTarget=32'h40 on handshake -> next imem_addr=32'h40, next pc=32'h40, misaligned stays 0.
4. instr_ready=0 for 5 cycles in HOLD -> instr and pc are stable, imem_req=0, no new fetch. PCSrc toggles during the stall have no effect.
5. PCTarget=32'h42 with PCSrc=1 -> imem_addr=32'h40 and misaligned pulses exactly 1 cycle.
6. Assert rst during WAIT, then deliver a stale rvalid in the first post-reset cycle -> stale data dropped, instr_valid=0, refetch from RESET_PC.
